// File: rtl/gpin_cond_pkg.sv
// gpin_cond_pkg: register map, debounce width and a byte-lane helper shared by the gpin_cond slice.
`default_nettype none

package gpin_cond_pkg;

    localparam logic [1:0] REG_STATE   = 2'd0;
    localparam logic [1:0] REG_EVENT   = 2'd1;
    localparam logic [1:0] REG_MASK    = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int         DBN_W       = 4;
    localparam logic [1:0] SEL_DEFAULT = 2'b10;

    // 32-bit enable covering the byte addressed by cpu_addr[1:0]
    function automatic logic [31:0] lane_mask(input logic [1:0] lane);
        return 32'h0000_00FF << {lane, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpin_debounce_bit.sv
// gpin_debounce_bit: one-bit synchroniser, tick-driven debounce counter and stable output flop.
// Counter logic exists only when GPIN_COND_DEBOUNCE_EN is defined; otherwise the stable flop tracks sync.
`default_nettype none

module gpin_debounce_bit
    import gpin_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pin_i,
`ifdef GPIN_COND_DEBOUNCE_EN
    input  logic             tick_i,
    input  logic [DBN_W-1:0] dbn_i,
`endif
    output logic             stable_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_q;
    logic                   stable_d;
    logic                   w_sync;

    assign w_sync   = sync_q[SYNC_STAGES-1];
    assign stable_o = stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
            stable_q <= stable_d;
        end
    end

`ifdef GPIN_COND_DEBOUNCE_EN
    logic [DBN_W-1:0] cnt_q;
    logic [DBN_W-1:0] cnt_d;

    // Compare with >= so a DBN lowered below an in-flight count still resolves
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (dbn_i == '0) begin
            stable_d = w_sync;
            cnt_d    = '0;
        end else if (w_sync == stable_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q >= dbn_i) begin
                stable_d = w_sync;
                cnt_d    = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        stable_d = w_sync;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/gpin_cond.sv
// gpin_cond: 32-bit input conditioner (sync, optional debounce, change events, irq) with a byte-wide CPU window.
// Build macro GPIN_COND_DEBOUNCE_EN adds the prescaler, per-bit counters and the CTRL register.
`default_nettype none

module gpin_cond
    import gpin_cond_pkg::*;
#(
    parameter logic [1:0] SEL         = SEL_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pin_in,
    output logic [31:0] gpin,
    input  logic [7:0]  cpu_do,
    input  logic [7:0]  cpu_addr,
    output logic [7:0]  cpu_di,
    input  logic        rd,
    input  logic        wr,
    output logic        irq
);

    logic [31:0] event_q, event_d;
    logic [31:0] mask_q,  mask_d;
    logic [31:0] gprev_q;
    logic [7:0]  cpu_di_q, cpu_di_d;
    logic        irq_q;

    logic        w_sel;
    logic [1:0]  w_reg;
    logic [1:0]  w_lane;
    logic [31:0] w_wmask;
    logic [31:0] w_wdata;
    logic [31:0] w_stable;
    logic [31:0] w_ctrl;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel    = (cpu_addr[7:6] == SEL);
    assign w_reg    = cpu_addr[3:2];
    assign w_lane   = cpu_addr[1:0];
    assign w_wmask  = lane_mask(w_lane);
    assign w_wdata  = {4{cpu_do}};
    assign w_unused = &{1'b0, rd, cpu_addr[5:4]};

`ifdef GPIN_COND_DEBOUNCE_EN
    logic [7:0]       presc_q, presc_d;
    logic [7:0]       pcnt_q,  pcnt_d;
    logic [DBN_W-1:0] dbn_q,   dbn_d;
    logic             w_tick;
    logic             w_wr_ctrl;

    assign w_wr_ctrl = wr && w_sel && (w_reg == REG_CTRL);
    assign w_tick    = (pcnt_q >= presc_q);
    assign w_ctrl    = {16'h0000, 4'h0, dbn_q, presc_q};

    // Writing PRESC restarts the shared prescaler from zero
    always_comb begin
        presc_d = presc_q;
        dbn_d   = dbn_q;
        pcnt_d  = w_tick ? 8'd0 : pcnt_q + 8'd1;
        if (w_wr_ctrl && (w_lane == 2'd0)) begin
            presc_d = cpu_do;
            pcnt_d  = 8'd0;
        end
        if (w_wr_ctrl && (w_lane == 2'd1)) begin
            dbn_d = cpu_do[DBN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            pcnt_q  <= '0;
            dbn_q   <= '0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            dbn_q   <= dbn_d;
        end
    end
`else
    assign w_ctrl = 32'h0000_0000;
`endif

    for (genvar i = 0; i < 32; i++) begin : g_bit
        gpin_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .pin_i    (pin_in[i]),
`ifdef GPIN_COND_DEBOUNCE_EN
            .tick_i   (w_tick),
            .dbn_i    (dbn_q),
`endif
            .stable_o (w_stable[i])
        );
    end

    always_comb begin
        mask_d  = mask_q;
        event_d = event_q;
        if (wr && w_sel && (w_reg == REG_MASK)) begin
            mask_d = (mask_q & ~w_wmask) | (w_wdata & w_wmask);
        end
        if (wr && w_sel && (w_reg == REG_EVENT)) begin
            event_d = event_q & ~(w_wdata & w_wmask);
        end
        // A fresh edge overrides a same-cycle clear
        event_d = event_d | (w_stable ^ gprev_q);
    end

    always_comb begin
        w_rdata = 32'h0000_0000;
        case (w_reg)
            REG_STATE: w_rdata = w_stable;
            REG_EVENT: w_rdata = event_q;
            REG_MASK:  w_rdata = mask_q;
            REG_CTRL:  w_rdata = w_ctrl;
            default:   w_rdata = 32'h0000_0000;
        endcase
        cpu_di_d = w_sel ? w_rdata[{w_lane, 3'b000} +: 8] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            event_q  <= '0;
            mask_q   <= '0;
            gprev_q  <= '0;
            cpu_di_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            event_q  <= event_d;
            mask_q   <= mask_d;
            gprev_q  <= w_stable;
            cpu_di_q <= cpu_di_d;
            irq_q    <= |(event_q & mask_q);
        end
    end

    assign gpin   = w_stable;
    assign cpu_di = cpu_di_q;
    assign irq    = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gpin_cond.sv
// tb_gpin_cond: table vectors, directed corner sequences and random traffic against a delay-line model.
`default_nettype none

module tb_gpin_cond;

    localparam int         S    = 2;
    localparam logic [1:0] SELV = 2'b10;
`ifdef GPIN_COND_DEBOUNCE_EN
    localparam logic [7:0] CTRL0_EXP = 8'h05;
`else
    localparam logic [7:0] CTRL0_EXP = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pin_in;
    logic [31:0] gpin;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_di;
    logic        rd;
    logic        wr;
    logic        irq;

    gpin_cond #(.SEL(SELV), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .pin_in(pin_in), .gpin(gpin),
        .cpu_do(cpu_do), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
        .rd(rd), .wr(wr), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit use_model;

    // Reference model: pins reach gpin after a pure S-edge delay line
    logic [31:0] m_gpin, m_gprev, m_event, m_mask;
    logic        m_irq;
    logic [7:0]  m_di, m_presc;
    logic [3:0]  m_dbn;
    logic [31:0] m_pq[$];

    function automatic logic [7:0] ad(input logic [1:0] w, input logic [1:0] r, input logic [1:0] l);
        return {w, 2'b00, r, l};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gpin = '0; m_gprev = '0; m_event = '0; m_mask = '0;
        m_irq = 1'b0; m_di = '0; m_presc = '0; m_dbn = '0;
        m_pq.delete();
        repeat (S) m_pq.push_back(32'h0);
    endtask

    task automatic model_edge();
        logic        sel;
        logic [1:0]  r, l;
        logic [31:0] wm, wd, rv, clr, n_gpin;
        if (reset) begin
            model_reset();
            return;
        end
        sel = (cpu_addr[7:6] == SELV);
        r   = cpu_addr[3:2];
        l   = cpu_addr[1:0];
        wm  = 32'hFF << (8 * l);
        wd  = {4{cpu_do}};
        case (r)
            2'd0:    rv = m_gpin;
            2'd1:    rv = m_event;
            2'd2:    rv = m_mask;
            default: rv = {20'h0, m_dbn, m_presc};
        endcase
        m_di  = sel ? 8'(rv >> (8 * l)) : 8'h00;
        m_irq = |(m_event & m_mask);
        clr   = (sel && wr && r == 2'd1) ? (wd & wm) : 32'h0;
        m_event = (m_event & ~clr) | (m_gpin ^ m_gprev);
        if (sel && wr && r == 2'd2) m_mask = (m_mask & ~wm) | (wd & wm);
`ifdef GPIN_COND_DEBOUNCE_EN
        if (sel && wr && r == 2'd3 && l == 2'd0) m_presc = cpu_do;
        if (sel && wr && r == 2'd3 && l == 2'd1) m_dbn = cpu_do[3:0];
`endif
        m_pq.push_back(pin_in);
        n_gpin  = m_pq.pop_front();
        m_gprev = m_gpin;
        m_gpin  = n_gpin;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        if (use_model) begin
            chk("gpin", gpin, m_gpin);
            chk("irq", {31'h0, irq}, {31'h0, m_irq});
            chk("cpu_di", {24'h0, cpu_di}, {24'h0, m_di});
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_do = d; wr = 1'b1;
        cycle();
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a);
        cpu_addr = a; rd = 1'b1;
        cycle();
        rd = 1'b0;
    endtask

    typedef struct {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        vt[0]  = '{1'b1, ad(SELV, 2'd2, 2'd0), 8'h20, 8'h00};
        vt[1]  = '{1'b0, ad(SELV, 2'd2, 2'd0), 8'h00, 8'h20};
        vt[2]  = '{1'b0, ad(SELV, 2'd2, 2'd1), 8'h00, 8'h00};
        vt[3]  = '{1'b1, ad(SELV, 2'd2, 2'd3), 8'hC3, 8'h00};
        vt[4]  = '{1'b0, ad(SELV, 2'd2, 2'd3), 8'h00, 8'hC3};
        vt[5]  = '{1'b0, ad(SELV, 2'd2, 2'd0), 8'h00, 8'h20};
        vt[6]  = '{1'b1, ad(2'b01, 2'd2, 2'd0), 8'hFF, 8'h00};
        vt[7]  = '{1'b0, ad(SELV, 2'd2, 2'd0), 8'h00, 8'h20};
        vt[8]  = '{1'b0, ad(2'b00, 2'd2, 2'd0), 8'h00, 8'h00};
        vt[9]  = '{1'b0, ad(2'b11, 2'd2, 2'd3), 8'h00, 8'h00};
        vt[10] = '{1'b0, ad(2'b01, 2'd2, 2'd0), 8'h00, 8'h00};
        vt[11] = '{1'b1, ad(SELV, 2'd3, 2'd0), 8'h05, 8'h00};
        vt[12] = '{1'b0, ad(SELV, 2'd3, 2'd0), 8'h00, CTRL0_EXP};
        vt[13] = '{1'b0, ad(SELV, 2'd3, 2'd2), 8'h00, 8'h00};
        vt[14] = '{1'b0, ad(SELV, 2'd3, 2'd3), 8'h00, 8'h00};
        vt[15] = '{1'b1, ad(SELV, 2'd3, 2'd0), 8'h00, 8'h00};
        vt[16] = '{1'b1, ad(SELV, 2'd0, 2'd0), 8'hFF, 8'h00};
        vt[17] = '{1'b0, ad(SELV, 2'd0, 2'd0), 8'h00, 8'h00};
        vt[18] = '{1'b1, ad(SELV, 2'd2, 2'd0), 8'h00, 8'h00};
        vt[19] = '{1'b1, ad(SELV, 2'd2, 2'd3), 8'h00, 8'h00};

        reset = 1'b1; pin_in = '0; cpu_do = '0; cpu_addr = '0; rd = 1'b0; wr = 1'b0;
        use_model = 1'b1;
        model_reset();
        repeat (3) cycle();
        reset = 1'b0;
        chk("rst_gpin", gpin, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_cpu_di", {24'h0, cpu_di}, 32'h0);

        // Register map vectors
        for (int i = 0; i < 20; i++) begin
            cpu_addr = vt[i].addr; cpu_do = vt[i].dat; wr = vt[i].is_wr;
            cycle();
            wr = 1'b0;
            if (!vt[i].is_wr) chk($sformatf("vec%0d", i), {24'h0, cpu_di}, {24'h0, vt[i].exp});
        end

        // Bypass latency and event capture
        pin_in = 32'hA5A5_0001;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            n++;
            if (gpin == 32'hA5A5_0001) break;
        end
        chk("bypass_latency", n, S + 1);
        cycle();
        for (int l = 0; l < 4; l++) begin
            logic [31:0] pat;
            pat = 32'hA5A5_0001;
            bus_rd(ad(SELV, 2'd1, 2'(l)));
            chk($sformatf("event_lane%0d", l), {24'h0, cpu_di}, {24'h0, pat[8*l +: 8]});
        end

        pin_in = '0;
        repeat (S + 3) cycle();
        for (int l = 0; l < 4; l++) bus_wr(ad(SELV, 2'd1, 2'(l)), 8'hFF);

        // EVENT[5] set, mask enables irq, clear drops it, clear vs new edge
        pin_in[5] = 1'b1;
        repeat (S + 2) cycle();
        chk("irq_masked", {31'h0, irq}, 32'h0);
        bus_rd(ad(SELV, 2'd1, 2'd0));
        chk("event5_set", {24'h0, cpu_di}, 32'h20);
        bus_wr(ad(SELV, 2'd2, 2'd0), 8'h20);
        cycle();
        chk("irq_on_mask", {31'h0, irq}, 32'h1);
        bus_wr(ad(SELV, 2'd1, 2'd0), 8'h20);
        chk("irq_hold_at_clear", {31'h0, irq}, 32'h1);
        cycle();
        chk("irq_after_clear", {31'h0, irq}, 32'h0);
        pin_in[5] = 1'b0;
        repeat (S + 1) cycle();
        bus_wr(ad(SELV, 2'd1, 2'd0), 8'h20);
        bus_rd(ad(SELV, 2'd1, 2'd0));
        chk("set_beats_clear", {24'h0, cpu_di}, 32'h20);

        // Random traffic, occasional resets
        for (int k = 0; k < 400; k++) begin
            int r;
            if ($urandom_range(0, 5) == 0) pin_in = pin_in ^ (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 40) == 0) pin_in = $urandom;
            reset = ($urandom_range(0, 150) == 0);
`ifdef GPIN_COND_DEBOUNCE_EN
            r = $urandom_range(0, 2);
`else
            r = $urandom_range(0, 3);
`endif
            cpu_addr = {($urandom_range(0, 4) == 0) ? 2'($urandom) : SELV, 2'b00, 2'(r), 2'($urandom)};
            cpu_do   = 8'($urandom);
            wr       = ($urandom_range(0, 3) == 0);
            cycle();
        end
        reset = 1'b0; wr = 1'b0;

`ifdef GPIN_COND_DEBOUNCE_EN
        begin
            int d;
            bit seen, found;
            reset = 1'b1; pin_in = '0;
            repeat (2) cycle();
            reset = 1'b0;
            use_model = 1'b0;
            bus_wr(ad(SELV, 2'd3, 2'd0), 8'h03);
            bus_wr(ad(SELV, 2'd3, 2'd1), 8'h04);
            bus_rd(ad(SELV, 2'd3, 2'd1));
            chk("dbn_readback", {24'h0, cpu_di}, 32'h04);
            seen = 1'b0;
            pin_in[5] = 1'b1;
            for (int k = 0; k < 40; k++) begin
                if (k == 10) pin_in[5] = 1'b0;
                cycle();
                if (gpin[5]) seen = 1'b1;
            end
            chk("glitch_gpin", {31'h0, seen}, 32'h0);
            bus_rd(ad(SELV, 2'd1, 2'd0));
            chk("glitch_event", {24'h0, cpu_di}, 32'h0);
            pin_in[5] = 1'b1;
            n = 0; found = 1'b0; seen = 1'b0;
            for (int k = 0; k < 60 && !found; k++) begin
                cycle();
                n++;
                if (irq) seen = 1'b1;
                if (gpin[5]) found = 1'b1;
            end
            d = n - S;
            total++;
            if (!found || d < 16 || d > 20) begin
                bad++;
                $display("FAIL deb_latency: got %0d clocks (found=%0d) required 16..20", d, found);
            end
            chk("deb_irq_masked", {31'h0, seen}, 32'h0);
            cycle();
            bus_rd(ad(SELV, 2'd1, 2'd0));
            chk("deb_event5", {24'h0, cpu_di}, 32'h20);
            bus_wr(ad(SELV, 2'd2, 2'd0), 8'h20);
            cycle();
            chk("deb_irq_on", {31'h0, irq}, 32'h1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
